// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter for memory-mapped stores.
// Bytes stored by the processor are queued in a small FIFO and sent 8N1,
// LSB first, on Tx. Define UART_TX_PARITY_EN to insert an even-parity
// bit between the data bits and the stop bit, giving 11-bit frames.
//
// Handshake: memwrite_uart is a fire-and-forget strobe with no ready
// return. A store seen while fifo_full=1 (the pre-edge value) is dropped
// and latches the sticky overflow flag. The producer may watch fifo_full
// or fifo_count to avoid losing data.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int ADDR_W       = 3
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              memwrite_uart,
  input  logic [7:0]        TxData,
  output logic              Tx,
  output logic              TxDone,
  output logic [7:0]        TxData_s,
  output logic              busy,
  output logic              fifo_full,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t              state;
  logic [BAUD_W-1:0]   baud;
  logic [2:0]          bit_idx;
  logic [7:0]          shift;
  logic [7:0]          mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W:0]     count_next;
  logic [7:0]          head;
  logic                baud_end;
  logic                push;
  logic                pop;

  // Push/pop decisions; fullness and emptiness use the pre-edge count.
  always_comb begin
    head     = mem[rd_ptr];
    baud_end = (baud == BAUD_MAX);
    push     = memwrite_uart & ~fifo_full;
    pop      = (fifo_count != '0) &
               ((state == S_IDLE) | ((state == S_STOP) & baud_end));
    count_next = fifo_count;
    case ({push, pop})
      2'b10:   count_next = fifo_count + (ADDR_W + 1)'(1);
      2'b01:   count_next = fifo_count - (ADDR_W + 1)'(1);
      default: count_next = fifo_count;
    endcase
  end

  // FIFO storage; contents need no reset because the count gates reads.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= TxData;
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_full  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      fifo_count <= count_next;
      fifo_full  <= (count_next == DEPTH_C);
      if (memwrite_uart & fifo_full) overflow <= 1'b1;
    end
  end

  // Transmit FSM with registered line, done pulse, debug byte and busy.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      Tx       <= 1'b1;
      TxDone   <= 1'b0;
      TxData_s <= '0;
      busy     <= 1'b0;
    end else begin
      TxDone <= 1'b0;
      case (state)
        S_IDLE: begin
          Tx <= 1'b1;
          if (pop) begin
            shift    <= head;
            TxData_s <= head;
            baud     <= '0;
            Tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= S_START;
          end
        end
        S_START: begin
          if (baud_end) begin
            baud    <= '0;
            bit_idx <= '0;
            Tx      <= shift[0];
            state   <= S_DATA;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              Tx    <= ^TxData_s;
              state <= S_PARITY;
`else
              Tx    <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              Tx      <= shift[1];
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_end) begin
            baud  <= '0;
            Tx    <= 1'b1;
            state <= S_STOP;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (baud_end) begin
            baud   <= '0;
            TxDone <= 1'b1;
            if (pop) begin
              // Next frame starts with no idle gap.
              shift    <= head;
              TxData_s <= head;
              Tx       <= 1'b0;
              state    <= S_START;
            end else begin
              Tx    <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        default: begin
          Tx    <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed frame table, multi-cycle corner sequences and a
// randomized run against a frame-timing reference model.
module tb_uart_tx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
  localparam bit PAR   = 1'b1;
`else
  localparam int NBITS = 10;
  localparam bit PAR   = 1'b0;
`endif
  localparam int FRAME = NBITS * CPB;

  logic          clk;
  logic          Reset;
  logic          memwrite_uart;
  logic [7:0]    TxData;
  logic          Tx;
  logic          TxDone;
  logic [7:0]    TxData_s;
  logic          busy;
  logic          fifo_full;
  logic [AW:0]   fifo_count;
  logic          overflow;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .Reset(Reset), .memwrite_uart(memwrite_uart), .TxData(TxData),
    .Tx(Tx), .TxDone(TxDone), .TxData_s(TxData_s), .busy(busy),
    .fifo_full(fifo_full), .fifo_count(fifo_count), .overflow(overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected serial level for bit slot idx of a frame carrying d.
  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (PAR && idx == 9) return ^d;
    return 1'b1;
  endfunction

  // ---------------- reference model ----------------
  // Tracks queued bytes and how many cycles remain of the frame on the line.
  logic [7:0] m_q[$];
  int         m_left;
  logic [7:0] m_cur;
  logic       m_ovf;
  logic       m_done;

  task automatic model_step(input logic wr, input logic [7:0] d);
    int pre;
    pre    = m_q.size();
    m_done = (m_left == 1);
    if (m_left > 0) m_left--;
    if (m_left == 0 && pre > 0) begin
      m_cur  = m_q.pop_front();
      m_left = FRAME;
    end
    if (wr) begin
      if (pre == DEPTH) m_ovf = 1'b1;
      else m_q.push_back(d);
    end
  endtask

  function automatic logic [16:0] model_outputs();
    logic tx_e;
    int   el;
    if (m_left == 0) tx_e = 1'b1;
    else begin
      el   = FRAME - m_left;
      tx_e = frame_bit(m_cur, el / CPB);
    end
    return {tx_e, m_done, (m_left != 0), (m_q.size() == DEPTH), m_ovf,
            4'(m_q.size()), m_cur};
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0] data;
    logic       exp_par;
  } vec_t;

  vec_t vecs[6];

  // ---------------- main sequence ----------------
  initial begin
    int bad_bits, bad_done, done_n, off, viol, pct, budget;
    logic [7:0] rx;
    logic       wr;
    logic       exp_b;

    vecs[0] = '{8'h55, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'hFF, 1'b0};
    vecs[3] = '{8'h00, 1'b0};
    vecs[4] = '{8'h80, 1'b1};
    vecs[5] = '{8'hA1, 1'b1};

    Reset = 1'b1;
    memwrite_uart = 1'b0;
    TxData = 8'h00;
    #250;
    check("rst_tx", Tx, 1);
    check("rst_done", TxDone, 0);
    check("rst_byte", TxData_s, 0);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_full", fifo_full, 0);
    check("rst_ovf", overflow, 0);
    Reset = 1'b0;

    // Idle line with no stores.
    viol = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (Tx !== 1'b1 || busy !== 1'b0 || fifo_count !== '0 || overflow !== 1'b0) viol++;
    end
    check("idle_quiet", viol, 0);

    // Single-byte frames from the table.
    for (int v = 0; v < 6; v++) begin
      memwrite_uart = 1'b1;
      TxData = vecs[v].data;
      tick();
      memwrite_uart = 1'b0;
      check("push_count", fifo_count, 1);
      check("pre_start_tx", Tx, 1);
      tick();
      check("start_tx", Tx, 0);
      check("start_busy", busy, 1);
      check("start_byte", TxData_s, vecs[v].data);
      check("start_count", fifo_count, 0);
      bad_bits = 0;
      bad_done = 0;
      for (int o = 0; o < FRAME; o++) begin
        if (PAR && (o / CPB) == 9) exp_b = vecs[v].exp_par;
        else exp_b = frame_bit(vecs[v].data, o / CPB);
        if (Tx !== exp_b) bad_bits++;
        if (TxDone !== 1'b0) bad_done++;
        tick();
      end
      check("frame_bits", bad_bits, 0);
      check("early_done", bad_done, 0);
      check("done_pulse", TxDone, 1);
      check("end_busy", busy, 0);
      check("end_tx", Tx, 1);
      tick();
      check("done_width", TxDone, 0);
      repeat (3) tick();
    end

    // Back-to-back stores produce contiguous frames.
    memwrite_uart = 1'b1;
    TxData = 8'hA1;
    tick();
    TxData = 8'hB2;
    tick();
    memwrite_uart = 1'b0;
    check("b2b_first_byte", TxData_s, 8'hA1);
    check("b2b_first_start", Tx, 0);
    done_n = 0;
    for (int o = 1; o <= 3 * FRAME; o++) begin
      tick();
      if (TxDone === 1'b1) begin
        done_n++;
        if (done_n == 1) begin
          check("b2b_done1_at", o, FRAME);
          check("b2b_gapless_start", Tx, 0);
          check("b2b_second_byte", TxData_s, 8'hB2);
        end else if (done_n == 2) begin
          check("b2b_done2_at", o, 2 * FRAME);
        end
      end
    end
    check("b2b_done_count", done_n, 2);
    check("b2b_idle", busy, 0);

    // Ten stores on consecutive edges into an eight-entry FIFO.
    for (int i = 1; i <= 10; i++) begin
      memwrite_uart = 1'b1;
      TxData = 8'(i);
      tick();
      if (i == 1) check("ovf_count1", fifo_count, 1);
      if (i == 2) begin
        check("ovf_count2", fifo_count, 1);
        check("ovf_pop_first", TxData_s, 8'h01);
        check("ovf_start", Tx, 0);
      end
      if (i == 8) begin
        check("ovf_count8", fifo_count, 7);
        check("ovf_not_full", fifo_full, 0);
      end
      if (i == 9) begin
        check("ovf_full", fifo_full, 1);
        check("ovf_count9", fifo_count, 8);
        check("ovf_not_yet", overflow, 0);
      end
      if (i == 10) begin
        check("ovf_set", overflow, 1);
        check("ovf_count10", fifo_count, 8);
      end
    end
    memwrite_uart = 1'b0;
    off = 8;
    rx = 8'h00;
    while (off < 9 * FRAME) begin
      tick();
      off++;
      if ((off % CPB) == CPB / 2 && ((off % FRAME) / CPB) >= 1 && ((off % FRAME) / CPB) <= 8)
        rx[((off % FRAME) / CPB) - 1] = Tx;
      if ((off % FRAME) == 5) check("ovf_inflight", TxData_s, 8'(off / FRAME + 1));
      if ((off % FRAME) == FRAME - 1) check("ovf_rx_byte", rx, 8'(off / FRAME + 1));
    end
    check("ovf_last_done", TxDone, 1);
    check("ovf_last_idle", busy, 0);
    check("ovf_sticky", overflow, 1);
    check("ovf_drained", fifo_count, 0);

    // Asynchronous reset in the middle of a frame with bytes queued.
    repeat (3) tick();
    memwrite_uart = 1'b1;
    TxData = 8'hFF;
    tick();
    TxData = 8'h11;
    tick();
    TxData = 8'h22;
    tick();
    TxData = 8'h33;
    tick();
    memwrite_uart = 1'b0;
    check("mid_queued", fifo_count, 3);
    repeat (5 * CPB - 3) tick();
    #3;
    Reset = 1'b1;
    #1;
    check("mid_rst_tx", Tx, 1);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", TxDone, 0);
    check("mid_rst_ovf", overflow, 0);
    repeat (3) tick();
    #2;
    Reset = 1'b0;
    viol = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      if (TxDone !== 1'b0 || Tx !== 1'b1 || busy !== 1'b0) viol++;
    end
    check("mid_no_frames", viol, 0);
    check("mid_count_after", fifo_count, 0);

    // Randomized stores against the reference model.
    m_q.delete();
    m_left = 0;
    m_cur  = 8'h00;
    m_ovf  = 1'b0;
    m_done = 1'b0;
    for (int ph = 0; ph < 3; ph++) begin
      pct = (ph == 0) ? 3 : ((ph == 1) ? 20 : 60);
      for (int n = 0; n < 1500; n++) begin
        wr = ($urandom_range(0, 99) < pct);
        memwrite_uart = wr;
        TxData = 8'($urandom_range(0, 255));
        tick();
        model_step(wr, TxData);
        check($sformatf("rand_cycle_ph%0d", ph),
              {Tx, TxDone, busy, fifo_full, overflow, fifo_count, TxData_s},
              model_outputs());
      end
    end
    memwrite_uart = 1'b0;
    budget = (DEPTH + 2) * FRAME;
    while ((m_left != 0 || m_q.size() != 0) && budget > 0) begin
      tick();
      model_step(1'b0, 8'h00);
      check("rand_drain",
            {Tx, TxDone, busy, fifo_full, overflow, fifo_count, TxData_s},
            model_outputs());
      budget--;
    end
    check("rand_drain_finished", budget > 0, 1);
    check("rand_final_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
